// File: rtl/uart_wb_tx_responder.sv
// Wishbone classic slave feeding a TX FIFO and an 8N1 serialiser with a programmable 16x baud divisor.
// Define UART_TX_PARITY_EN to add the LCR register (address 5) and a parity bit between DATA and STOP.
module uart_wb_tx_responder #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd27
) (
  input  logic       clock,
  input  logic       wb_rst_i,
  input  logic [4:0] wb_addr_i,
  input  logic [3:0] wb_sel_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       int_o,
  output logic       baud_o,
  output logic       stx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic          ack_q, ack_d;
  logic [7:0]    dat_q, dat_d;
  logic          int_q, int_d;
  logic          ier_q, ier_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    dll_q, dll_d;
  logic [7:0]    dlm_q, dlm_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          baud_q, baud_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic [1:0]    lcr_q, lcr_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
`endif

  logic          acc, wr_en, rd_en;
  logic          push_req, push_ok, pop;
  logic          fifo_full, fifo_empty, temt, tick;
  logic [7:0]    head, lsr;
  logic [15:0]   div;
  logic          sel_unused;

  assign sel_unused = ^wb_sel_i[3:1];

  assign acc        = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en      = acc & wb_we_i & wb_sel_i[0];
  assign rd_en      = acc & ~wb_we_i;
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign temt       = fifo_empty & (state_q == S_IDLE);
  assign tick       = baud_q;
  assign head       = mem_q[rptr_q];
  assign div        = {dlm_q, dll_q};
  assign lsr        = {1'b0, temt, fifo_empty, 3'b000, ovr_q, fifo_full};

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign int_o    = int_q;
  assign baud_o   = baud_q;

  // Bus decode: register writes and read-data capture happen on the acking edge
  always_comb begin
    ack_d    = acc;
    ier_d    = ier_q;
    dll_d    = dll_q;
    dlm_d    = dlm_q;
    push_req = 1'b0;
`ifdef UART_TX_PARITY_EN
    lcr_d    = lcr_q;
`endif
    if (wr_en) begin
      case (wb_addr_i)
        5'd0: push_req = 1'b1;
        5'd1: ier_d    = wb_dat_i[0];
        5'd3: dll_d    = wb_dat_i;
        5'd4: dlm_d    = wb_dat_i;
`ifdef UART_TX_PARITY_EN
        5'd5: lcr_d    = wb_dat_i[1:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    dat_d = 8'h00;
    if (rd_en) begin
      case (wb_addr_i)
        5'd1: dat_d = {7'b0, ier_q};
        5'd2: dat_d = lsr;
        5'd3: dat_d = dll_q;
        5'd4: dat_d = dlm_q;
`ifdef UART_TX_PARITY_EN
        5'd5: dat_d = {6'b0, lcr_q};
`endif
        default: dat_d = 8'h00;
      endcase
    end
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    push_ok = push_req & (~fifo_full | pop);
    ovr_d   = ovr_q;
    if (push_req & ~push_ok)
      ovr_d = 1'b1;
    else if (rd_en && (wb_addr_i == 5'd2))
      ovr_d = 1'b0;
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    int_d = ier_q & temt;
  end

  // Baud divider: a zero divisor freezes the counter and therefore the whole transmitter
  always_comb begin
    baud_d = 1'b0;
    cnt_d  = cnt_q;
    if (div != 16'd0) begin
      if (cnt_q == 16'd0) begin
        baud_d = 1'b1;
        cnt_d  = div - 16'd1;
      end else begin
        cnt_d  = cnt_q - 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          sub_d = 4'd0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end
        end
        S_START: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end
        end
        S_DATA: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shreg_d = {1'b0, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = par_en_q ? S_PAR : S_STOP;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PAR: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15)
            state_d = S_STOP;
        end
`endif
        S_STOP: begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Line settings are latched with the byte so later LCR writes leave this frame alone
    if (pop) begin
      shreg_d = head;
`ifdef UART_TX_PARITY_EN
      par_en_d  = lcr_q[0];
      par_bit_d = lcr_q[1] ? ~^head : ^head;
`endif
    end
  end

  always_comb begin
    stx_o = 1'b1;
    case (state_q)
      S_START: stx_o = 1'b0;
      S_DATA:  stx_o = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      S_PAR:   stx_o = par_bit_q;
`endif
      default: stx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 8'h00;
      int_q   <= 1'b0;
      ier_q   <= 1'b0;
      ovr_q   <= 1'b0;
      dll_q   <= DIV_RESET[7:0];
      dlm_q   <= DIV_RESET[15:8];
      cnt_q   <= DIV_RESET - 16'd1;
      baud_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      sub_q   <= 4'd0;
      bit_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
      lcr_q    <= 2'b00;
      par_en_q <= 1'b0;
`endif
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      int_q   <= int_d;
      ier_q   <= ier_d;
      ovr_q   <= ovr_d;
      dll_q   <= dll_d;
      dlm_q   <= dlm_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
`ifdef UART_TX_PARITY_EN
      lcr_q    <= lcr_d;
      par_en_q <= par_en_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem_q[wptr_q] <= wb_dat_i;
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_bit_q <= par_bit_d;
`endif
  end

endmodule

// File: tb/tb_uart_wb_tx_responder.sv
// Directed bench for uart_wb_tx_responder: register access, framing, overrun, interrupt and reset.
module tb_uart_wb_tx_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] addr = '0;
  logic [3:0] sel = '0;
  logic [7:0] dat_i = '0;
  logic [7:0] dat_o;
  logic       we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic       ack, irq, baud, stx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_wb_tx_responder dut (
    .clock(clk), .wb_rst_i(rst), .wb_addr_i(addr), .wb_sel_i(sel),
    .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack), .int_o(irq), .baud_o(baud), .stx_o(stx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    addr = a; dat_i = d; we = 1'b1; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ack !== 1'b1 && n < 4);
    check_eq("wr_ack", ack, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [4:0] a, output logic [7:0] d);
    int n;
    @(negedge clk);
    addr = a; we = 1'b0; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ack !== 1'b1 && n < 4);
    check_eq("rd_ack", ack, 1'b1);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Waits for a start bit, then samples each bit in the middle of its 16-clock slot (DIV=1)
  task automatic capture_frame(input int nbits, output logic [10:0] bits, output int waited);
    bits = '1;
    waited = 0;
    while (stx !== 1'b0 && waited < 400) begin
      @(negedge clk); waited++;
    end
    check_eq("frame_start", (waited < 400), 1'b1);
    for (int i = 0; i < nbits; i++) begin
      repeat ((i == 0) ? 8 : 16) @(negedge clk);
      bits[i] = stx;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [10:0] bits;
    logic [7:0]  exp_b;
    int          waited, w;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stx", stx, 1'b1);
    check_eq("rst_ack", ack, 1'b0);
    check_eq("rst_int", irq, 1'b0);
    check_eq("rst_baud", baud, 1'b0);
    check_eq("rst_dat", dat_o, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    wb_read(5'd2, rd); check_eq("rst_lsr", rd, 8'h60);
    wb_read(5'd3, rd); check_eq("rst_dll", rd, 8'd27);
    wb_read(5'd4, rd); check_eq("rst_dlm", rd, 8'd0);
    wb_read(5'd1, rd); check_eq("rst_ier", rd, 8'd0);

    w = 0;
    while (baud !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    check_eq("baud_seen", (w < 100), 1'b1);
    w = 0;
    do begin @(negedge clk); w++; end while (baud !== 1'b1 && w < 100);
    check_eq("baud_period", w, 27);

    repeat (2) @(negedge clk);
    addr = 5'd9; we = 1'b0; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("hs_ack%0d", i), ack, (i % 2) == 1);
      check_eq($sformatf("hs_dat%0d", i), dat_o, 8'h00);
    end
    cyc = 1'b0; stb = 1'b0;

    wb_write(5'd3, 8'd1);
    repeat (40) @(negedge clk);
    wb_write(5'd1, 8'd1);
    repeat (2) @(negedge clk);
    check_eq("int_idle_high", irq, 1'b1);

    wb_write(5'd0, 8'hA5);
    capture_frame(10, bits, waited);
    check_eq("frame_a5", bits[9:0], {1'b1, 8'hA5, 1'b0});
    check_eq("int_low_tx", irq, 1'b0);
    repeat (7) @(negedge clk);
    check_eq("int_low_stop_end", irq, 1'b0);
    @(negedge clk);
    check_eq("int_low_idle0", irq, 1'b0);
    @(negedge clk);
    check_eq("int_rise", irq, 1'b1);
    wb_read(5'd2, rd); check_eq("lsr_temt", rd, 8'h60);
    wb_write(5'd1, 8'd0);
    @(posedge clk); #1;
    check_eq("int_clear", irq, 1'b0);

    wb_write(5'd3, 8'd0);
    for (int i = 0; i < 17; i++) wb_write(5'd0, 8'h10 + 8'(i));
    wb_read(5'd2, rd); check_eq("lsr_ovr", rd, 8'h03);
    wb_read(5'd2, rd); check_eq("lsr_ovr_clr", rd, 8'h01);
    wb_write(5'd3, 8'd1);
    for (int f = 0; f < 16; f++) begin
      capture_frame(10, bits, waited);
      exp_b = 8'h10 + 8'(f);
      check_eq($sformatf("ovr_frame%0d", f), bits[9:0], {1'b1, exp_b, 1'b0});
      if (f > 0) check_eq($sformatf("ovr_gap%0d", f), waited, 8);
    end
    repeat (20) @(negedge clk);
    wb_read(5'd2, rd); check_eq("lsr_drained", rd, 8'h60);

`ifdef UART_TX_PARITY_EN
    wb_write(5'd5, 8'h01);
    wb_write(5'd0, 8'h07);
    capture_frame(11, bits, waited);
    check_eq("par_even", bits[9], 1'b1);
    check_eq("par_even_frame", bits, {1'b1, 1'b1, 8'h07, 1'b0});
    repeat (20) @(negedge clk);
    wb_write(5'd5, 8'h03);
    wb_write(5'd0, 8'h07);
    capture_frame(11, bits, waited);
    check_eq("par_odd", bits[9], 1'b0);
    check_eq("par_odd_frame", bits, {1'b1, 1'b0, 8'h07, 1'b0});
    repeat (20) @(negedge clk);
    wb_read(5'd5, rd); check_eq("lcr_read", rd, 8'h03);
`else
    wb_write(5'd5, 8'h03);
    wb_read(5'd5, rd); check_eq("reg5_zero", rd, 8'h00);
`endif

    wb_write(5'd0, 8'h00);
    capture_frame(3, bits, waited);
    check_eq("mid_data_low", stx, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_stx", stx, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wb_read(5'd2, rd); check_eq("rst2_lsr", rd, 8'h60);
    wb_read(5'd3, rd); check_eq("rst2_dll", rd, 8'd27);
    repeat (40) @(negedge clk);
    check_eq("rst2_stx_idle", stx, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
